// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the round-robin ALU scheduler:
//   - ALU opcode constants (OP_AND .. OP_SLT)
//   - is_legal_op(): true for the seven opcodes the ALU implements
//   - state_t: scheduler FSM state encoding
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at ptr and searching
// upward (wrapping at NREQ), the first set request bit wins.
// Ports:
//   req  in   NREQ        request vector
//   ptr  in   log2(NREQ)  highest-priority index this round
//   win  out  NREQ        one-hot winner (all zero when req == 0)
//   idx  out  log2(NREQ)  encoded winner (0 when req == 0)
// NREQ must be a power of two so the index wraps by plain truncation.
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW-1:0] cand;

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + PW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ----------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one pipelined ALU between NREQ requesters. One request is accepted
// at a time (round-robin), its operands/opcode are driven to the ALU and held
// while the ALU pipeline runs, and the sampled result is returned to the
// granted requester with a one-cycle resp_valid pulse. Illegal opcodes skip
// the ALU and are answered one cycle after the grant with resp_err=1.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req          in   NREQ     per-requester request level
//   req_op       in   4*NREQ   opcode of requester i in [4i+3:4i]
//   req_a/req_b  in   W*NREQ   operands of requester i in [Wi+W-1:Wi]
//   gnt          out  NREQ     one-hot pulse: that requester's op was accepted
//   resp_valid   out  NREQ     one-hot pulse: resp_result/resp_err valid
//   resp_result  out  W        result, held until the next response
//   resp_err     out  1        illegal opcode flag, held like resp_result
//   busy         out  1        scheduler not in IDLE
//   alu_a/alu_b  out  W        ALU operands
//   alu_op       out  4        ALU opcode
//   alu_result   in   W        ALU result, sampled ALU_LAT edges after issue
// ----------------------------------------------------------------------------
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int ALU_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_result,
    output logic              resp_err,
    output logic              busy,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [W-1:0]      alu_result
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   owner, owner_d;   // requester currently being served
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] gnt_d, rv_d;
    logic [W-1:0]    res_d, a_d, b_d;
    logic            err_d;
    logic [3:0]      op_d;

    logic [NREQ-1:0] pick_win;
    logic [PW-1:0]   pick_idx;
    logic [3:0]      sel_op;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx)
    );

    assign sel_op = req_op[{pick_idx, 2'b00} +: 4];
    assign busy   = (state != ST_IDLE);

    // Next-state and next-output logic; every register holds by default and
    // the pulses default to zero.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        gnt_d   = '0;
        rv_d    = '0;
        res_d   = resp_result;
        err_d   = resp_err;
        a_d     = alu_a;
        b_d     = alu_b;
        op_d    = alu_op;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + 1'b1;   // wraps: NREQ is a power of two
                    if (is_legal_op(sel_op)) begin
                        a_d     = req_a[pick_idx*W +: W];
                        b_d     = req_b[pick_idx*W +: W];
                        op_d    = sel_op;
                        cnt_d   = CW'(ALU_LAT - 1);
                        state_d = ST_WAIT;
                    end else begin
                        // ALU lines are left untouched; the error is answered
                        // without involving the ALU.
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    res_d       = alu_result;
                    err_d       = 1'b0;
                    rv_d[owner] = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_ERR: begin
                res_d       = '0;
                err_d       = 1'b1;
                rv_d[owner] = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: all registers here are small control/datapath flops, so each one
    // is cleared by the asynchronous reset; an abort in WAIT leaves nothing
    // behind that could later produce a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            gnt         <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 4'b0000;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            owner       <= owner_d;
            cnt         <= cnt_d;
            gnt         <= gnt_d;
            resp_valid  <= rv_d;
            resp_result <= res_d;
            resp_err    <= err_d;
            alu_a       <= a_d;
            alu_b       <= b_d;
            alu_op      <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Directed bench for alu_rr_scheduler with a behavioural 2-register ALU
// (opcode/operand register, result register) so the scheduler samples the
// result on its third edge after issue.
// ----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int ALU_LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_result;
    logic              resp_err;
    logic              busy;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_op;
    logic [W-1:0]      alu_result;

    int checks = 0;
    int errors = 0;

    alu_rr_scheduler #(.NREQ(NREQ), .W(W), .ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: two pipeline registers.
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, b);
        case (op)
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0111: return ~(a | b);
            4'b0110: return a ^ b;
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    logic [W-1:0] alu_r1 = '0;
    logic [W-1:0] alu_r2 = '0;
    always @(posedge clk) begin
        alu_r1 <= alu_f(alu_op, alu_a, alu_b);
        alu_r2 <= alu_r1;
    end
    assign alu_result = alu_r2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int r, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[4*r +: 4] = op;
        req_a[W*r +: W]  = a;
        req_b[W*r +: W]  = b;
    endtask

    // One legal op from a single requester: grant at E0, ALU lines stable,
    // response at E_ALU_LAT.
    task automatic run_single(input string tag, input int r, input logic [3:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_res);
        logic [NREQ-1:0] onehot;
        onehot    = '0;
        onehot[r] = 1'b1;
        set_lane(r, op, a, b);
        req = onehot;
        step();
        check({tag, " gnt"}, gnt, onehot);
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " alu_lines"}, {alu_op, alu_a, alu_b}, {op, a, b});
        req = '0;
        repeat (ALU_LAT - 1) begin
            step();
            check({tag, " wait_pulses"}, {gnt, resp_valid}, '0);
            check({tag, " alu_hold"}, {alu_op, alu_a, alu_b}, {op, a, b});
        end
        step();
        check({tag, " resp_valid"}, resp_valid, onehot);
        check({tag, " resp_result"}, resp_result, exp_res);
        check({tag, " resp_err"}, resp_err, 1'b0);
        check({tag, " alu_hold_e3"}, {alu_op, alu_a, alu_b}, {op, a, b});
        check({tag, " idle"}, {busy, gnt}, '0);
    endtask

    initial begin
        logic [NREQ-1:0] exp_onehot;

        reset  = 1'b0;
        req    = '0;
        req_op = '0;
        req_a  = '0;
        req_b  = '0;

        // 1. Reset and idle.
        repeat (3) step();
        check("reset outputs", {gnt, resp_valid, resp_err, busy, alu_op}, '0);
        check("reset data", {alu_a, resp_result}, '0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle outputs", {gnt, resp_valid, resp_err, busy, alu_op, alu_a}, '0);
        end

        // 2. Single ADD from requester 2: 5 + 3.
        run_single("add_r2", 2, 4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008);
        step();
        check("add_r2 result_hold", {resp_valid, resp_result}, {4'b0000, 32'h0000_0008});

        // Other legal opcodes, then a requester-3 ADD that wraps the
        // pointer back to 0.
        run_single("and_r0", 0, 4'b0100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034);
        run_single("or_r1",  1, 4'b0101, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF);
        run_single("nor_r2", 2, 4'b0111, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00);
        run_single("xor_r1", 1, 4'b0110, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB);
        run_single("slt_r0", 0, 4'b1010, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h0000_0001);
        run_single("sub_r2", 2, 4'b0010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
        run_single("add_r3", 3, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);

        // 3. Round robin: all requesters hold SUB (10+i) - i.
        for (int i = 0; i < NREQ; i++) set_lane(i, 4'b0010, 32'(10 + i), 32'(i));
        req = '1;
        for (int k = 0; k < 5; k++) begin
            exp_onehot = '0;
            exp_onehot[k % NREQ] = 1'b1;
            step();
            check("rr gnt", gnt, exp_onehot);
            check("rr alu_a", alu_a, 32'(10 + (k % NREQ)));
            repeat (ALU_LAT - 1) step();
            check("rr wait_no_gnt", gnt, '0);
            step();
            check("rr resp_valid", resp_valid, exp_onehot);
            check("rr result", resp_result, 32'd10);
        end
        req = '0;

        // 4. Illegal opcode from requester 1; ALU lines keep the last SUB.
        set_lane(1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        req = 4'b0010;
        step();
        check("ill gnt", gnt, 4'b0010);
        check("ill alu_kept", {alu_op, alu_a, alu_b}, {4'b0010, 32'd10, 32'd0});
        req = '0;
        step();
        check("ill resp_valid", resp_valid, 4'b0010);
        check("ill resp", {resp_err, resp_result}, {1'b1, 32'h0});
        check("ill alu_op", alu_op, 4'b0010);
        check("ill idle", {busy, gnt}, '0);

        // 5. Reset in the middle of an XOR from requester 3.
        set_lane(3, 4'b0110, 32'h0000_F0F0, 32'h0000_0FF0);
        req = 4'b1000;
        step();
        check("abort gnt", gnt, 4'b1000);
        req = '0;
        step();
        reset = 1'b0;
        #1;
        check("abort cleared", {gnt, resp_valid, resp_err, busy, alu_op}, '0);
        check("abort data", {alu_a, alu_b, resp_result}, '0);
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort no_resp", {resp_valid, busy}, '0);
        end
        run_single("post_reset_r0", 0, 4'b0000, 32'd7, 32'd9, 32'd16);

        // 6. Pointer wrap with sparse requests.
        run_single("wrap_r3", 3, 4'b0000, 32'd100, 32'd23, 32'h0000_007B);
        set_lane(0, 4'b0000, 32'd1, 32'd2);
        set_lane(3, 4'b0100, 32'h0000_FF00, 32'h0000_0FF0);
        req = 4'b1001;
        step();
        check("sparse gnt0", gnt, 4'b0001);
        repeat (ALU_LAT - 1) step();
        step();
        check("sparse resp0", {resp_valid, resp_result}, {4'b0001, 32'd3});
        step();
        check("sparse gnt3", gnt, 4'b1000);
        check("sparse no_overlap", resp_valid, '0);
        req = '0;
        repeat (ALU_LAT - 1) step();
        step();
        check("sparse resp3", {resp_valid, resp_result, resp_err}, {4'b1000, 32'h0000_0F00, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 7-op 32-bit ALU between NREQ requesters using round-robin arbitration.
- Accepts one request at a time, drives the ALU operand and opcode lines, and holds them stable for the ALU's fixed pipeline latency.
- Captures the ALU result and returns it to the granted requester with a one-cycle response pulse.
- Sits between the requesting units (decode/issue blocks) and the ALU datapath.

Parameters:
- NREQ, 4: number of requesters; must be a power of two; range 2..8.
- W, 32: operand/result width.
- ALU_LAT, 3: edges after issue at which alu_result is sampled. Breakdown: 1 opcode register, 1 result register, 1 capture. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_op  in  4*NREQ  opcode of requester i, in bits [4i+3:4i].
- req_a  in  W*NREQ  operand A of requester i.
- req_b  in  W*NREQ  operand B of requester i.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester were accepted.
- resp_valid  out  NREQ  one-hot, one-cycle pulse; resp_result/resp_err are valid for that requester.
- resp_result  out  W  result, shared by all requesters.
- resp_err  out  1  opcode was illegal; qualified by resp_valid.
- busy  out  1  high in any state other than IDLE.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  4  to ALU opcode input.
- alu_result  in  W  from ALU result.

Behaviour:
Reset:
- reset low asynchronously clears all of the following: state=IDLE, rr pointer=0, gnt=0, resp_valid=0, resp_result=0, resp_err=0, busy=0, alu_a=0, alu_b=0, alu_op=4'b0000, cnt=0.
- reset during WAIT aborts the operation; no response is ever issued for it.

Legal opcodes:
- AND 4'b0100, OR 4'b0101, NOR 4'b0111, XOR 4'b0110, ADD 4'b0000, SUB 4'b0010, SLT 4'b1010.
- Any other value is illegal.

FSM states: IDLE, WAIT, ERR.

IDLE:
- On an edge where req != 0, select the winner: the first set req bit searching from the rr pointer upward, wrapping at NREQ.
- Latch the winner's op/A/B into alu_op/alu_a/alu_b and pulse gnt[winner].
- Set rr pointer to (winner+1) mod NREQ.
- Legal opcode: go to WAIT with cnt=ALU_LAT-1.
- Illegal opcode: go to ERR; alu_* outputs keep their previous values.
- No request: stay in IDLE; all outputs hold, pulses are 0.

WAIT:
- alu_a/alu_b/alu_op are held constant for the whole state.
- req is ignored, and no gnt is issued.
- If cnt != 0, decrement cnt.
- If cnt == 0, capture alu_result into resp_result, set resp_err=0, pulse resp_valid[winner], and go to IDLE.

ERR:
- On the next edge: resp_result=0, resp_err=1, pulse resp_valid[winner], go to IDLE.

Timing:
- Issue edge E0: gnt is high in cycle E0..E1.
- resp_valid is high in cycle E_ALU_LAT..E_ALU_LAT+1.
- Peak throughput is one op per ALU_LAT+1 cycles.
- Illegal ops respond at E1.

Handshake and output rules:
- A requester must drop req (or present a new op) in the cycle gnt is seen. A req still high in IDLE is taken as a new request.
- gnt and resp_valid are never high simultaneously for the same requester in one cycle.
- resp_result and resp_err hold their values until the next response.
- busy = (state != IDLE).

Boundary cases:
- All req bits high: service order is strict rotation 0,1,2,3,0,...
- Single requester repeatedly requesting: served every ALU_LAT+1 cycles.
- Pointer wrap from NREQ-1 to 0 follows the mod rule.
- A request arriving on the same edge a response is issued is sampled on the following edge, which is when the scheduler is in IDLE.

Decomposition:
- Shared package alu_pkg holds the opcode constants (OP_AND, OP_OR, OP_NOR, OP_XOR, OP_ADD, OP_SUB, OP_SLT), the function is_legal_op, and the state encoding.
- One natural sub-module, rr_pick: combinational round-robin priority picker with inputs req[NREQ] and ptr, and outputs one-hot win plus encoded idx.

Test Plan:
1. Reset/idle: hold reset low for 3 cycles, then release with req=0. Expected: all outputs 0, busy=0 for 10 cycles.
2. Single ADD: requester 2, op 4'b0000, A=32'h0000_0005, B=32'h0000_0003.
   - Expected gnt=4'b0100 at E0.
   - alu_op/alu_a/alu_b are stable through E3.
   - With the behavioural ALU model, resp_valid=4'b0100 at E3, resp_result=32'h8, resp_err=0.
3. Round-robin: all 4 req held high, each with SUB A=10+i, B=i.
   - Expected grant order 0,1,2,3,0 at 4-cycle spacing.
   - Every result is 10.
4. Illegal opcode: requester 1 with op 4'b1111.
   - Expected gnt=4'b0010, then resp_valid=4'b0010 next cycle, resp_err=1, resp_result=0.
   - alu_op unchanged.
5. Reset mid-op: issue XOR from requester 3, then pull reset low at E1.
   - Expected: outputs clear immediately and no resp_valid for requester 3.
   - After release, a new request from requester 0 is granted first, since pointer=0.
6. Pointer wrap with sparse requests: requester 3 served, then req=4'b1001.
   - Expected: next grant goes to requester 0, then to 3.
